aud_mode_ctrl: RTL and testbench



---
 rtl/aud_pkg.sv | 41 ++++
 rtl/aud_mode_ctrl_if.sv | 41 ++++
 rtl/aud_sec_timer.sv | 37 +++
 rtl/aud_mode_ctrl.sv | 123 ++++++++++++
 tb/tb_aud_mode_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/aud_pkg.sv
// Shared types for the audio mode controller: FSM states, key codes and the
// bundle of one-cycle command pulses sent to the recorder and DSP.
package aud_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RECORD     = 3'd2,
    ST_REC_PAUSE  = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  // Key codes double as bit positions in the {play, record, stop} key vector.
  typedef enum logic [1:0] {
    KEY_STOP = 2'd0,
    KEY_REC  = 2'd1,
    KEY_PLAY = 2'd2,
    KEY_NONE = 2'd3
  } key_t;

  // Highest priority first.
  localparam key_t KEY_PRIO [3] = '{KEY_STOP, KEY_REC, KEY_PLAY};

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic dsp_start;
    logic dsp_pause;
    logic dsp_stop;
  } cmd_t;

  // Walk from lowest to highest priority so the strongest pressed key wins.
  function automatic key_t key_pick(input logic [2:0] pressed);
    key_pick = KEY_NONE;
    for (int i = 2; i >= 0; i--)
      if (pressed[KEY_PRIO[i]]) key_pick = KEY_PRIO[i];
  endfunction

endpackage

// File: rtl/aud_mode_ctrl_if.sv
// Key/status inputs and command/display outputs of the audio mode controller.
interface aud_mode_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int TIME_W = 6
);
  logic              i_key_record;
  logic              i_key_play;
  logic              i_key_stop;
  logic              i_init_done;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_full;
  logic              i_play_end;
  logic              o_i2c_start;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_dsp_start;
  logic              o_dsp_pause;
  logic              o_dsp_stop;
  logic [ADDR_W-1:0] o_end_addr;
  logic              o_sram_rec;
  logic [2:0]        o_state;
  logic [TIME_W-1:0] o_record_time;
  logic [TIME_W-1:0] o_play_time;

  modport slave (
    input  i_key_record, i_key_play, i_key_stop, i_init_done, i_rec_addr,
           i_rec_full, i_play_end,
    output o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start,
           o_dsp_pause, o_dsp_stop, o_end_addr, o_sram_rec, o_state,
           o_record_time, o_play_time
  );

  modport master (
    output i_key_record, i_key_play, i_key_stop, i_init_done, i_rec_addr,
           i_rec_full, i_play_end,
    input  o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start,
           o_dsp_pause, o_dsp_stop, o_end_addr, o_sram_rec, o_state,
           o_record_time, o_play_time
  );
endinterface

// File: rtl/aud_sec_timer.sv
// Sub-second tick counter feeding a saturating seconds counter; clear wins
// over enable, and the count holds whenever enable is low.
module aud_sec_timer #(
  parameter int TICKS_PER_SEC = 12_000_000,
  parameter int TIME_W        = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  output logic [TIME_W-1:0] o_time
);
  localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICKS_PER_SEC - 1);

  logic [TW-1:0]     r_tick;
  logic [TIME_W-1:0] r_time;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_time <= '0;
    end else if (i_clr) begin
      r_tick <= '0;
      r_time <= '0;
    end else if (i_en) begin
      if (r_tick == LAST) begin
        r_tick <= '0;
        if (r_time != '1) r_time <= r_time + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign o_time = r_time;
endmodule

// File: rtl/aud_mode_ctrl.sv
// Audio record/playback mode FSM: codec init kick-off, key-to-command
// translation, end-address latch, SRAM ownership and the two seconds displays.
module aud_mode_ctrl
  import aud_pkg::*;
#(
  parameter int TICKS_PER_SEC = 12_000_000,
  parameter int ADDR_W        = 20,
  parameter int TIME_W        = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  aud_mode_ctrl_if.slave  bus
);
  state_t            r_state;
  cmd_t              r_cmd;
  logic [ADDR_W-1:0] r_end_addr;
  logic              r_sram_rec;
  logic              r_i2c_start;
  logic              r_i2c_sent;

  logic [2:0] w_mask;
  key_t       w_key;
  logic       w_rec_stop, w_play_stop, w_clr_rec, w_clr_play;

  // Only keys meaningful in the current state take part in priority; stop is
  // kept in IDLE so that it still masks a simultaneous record/play.
  always_comb begin
    w_mask = 3'b000;
    case (r_state)
      ST_IDLE:                    w_mask = 3'b111;
      ST_RECORD, ST_REC_PAUSE:    w_mask = 3'b011;
      ST_PLAY, ST_PLAY_PAUSE:     w_mask = 3'b101;
      default:                    w_mask = 3'b000;
    endcase
  end

  assign w_key = key_pick({bus.i_key_play, bus.i_key_record, bus.i_key_stop} & w_mask);

  assign w_rec_stop  = ((r_state == ST_RECORD) && ((w_key == KEY_STOP) || bus.i_rec_full)) ||
                       ((r_state == ST_REC_PAUSE) && (w_key == KEY_STOP));
  assign w_play_stop = ((r_state == ST_PLAY) && ((w_key == KEY_STOP) || bus.i_play_end)) ||
                       ((r_state == ST_PLAY_PAUSE) && (w_key == KEY_STOP));
  assign w_clr_rec   = (r_state == ST_IDLE) && (w_key == KEY_REC);
  assign w_clr_play  = ((r_state == ST_IDLE) && (w_key == KEY_PLAY)) || w_play_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_INIT;
      r_cmd       <= '0;
      r_end_addr  <= '0;
      r_sram_rec  <= 1'b0;
      r_i2c_start <= 1'b0;
      r_i2c_sent  <= 1'b0;
    end else begin
      r_cmd       <= '0;
      r_i2c_start <= ~r_i2c_sent;
      r_i2c_sent  <= 1'b1;
      case (r_state)
        ST_INIT: if (bus.i_init_done) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_key == KEY_REC) begin
            r_state         <= ST_RECORD;
            r_sram_rec      <= 1'b1;
            r_cmd.rec_start <= 1'b1;
          end else if ((w_key == KEY_PLAY) && (r_end_addr != '0)) begin
            r_state         <= ST_PLAY;
            r_cmd.dsp_start <= 1'b1;
          end
        end
        ST_RECORD, ST_REC_PAUSE: begin
          if (w_rec_stop) begin
            r_state        <= ST_IDLE;
            r_sram_rec     <= 1'b0;
            r_cmd.rec_stop <= 1'b1;
            r_end_addr     <= bus.i_rec_addr;
          end else if (w_key == KEY_REC) begin
            r_state         <= (r_state == ST_RECORD) ? ST_REC_PAUSE : ST_RECORD;
            r_cmd.rec_pause <= (r_state == ST_RECORD);
            r_cmd.rec_start <= (r_state == ST_REC_PAUSE);
          end
        end
        ST_PLAY, ST_PLAY_PAUSE: begin
          if (w_play_stop) begin
            r_state        <= ST_IDLE;
            r_cmd.dsp_stop <= 1'b1;
          end else if (w_key == KEY_PLAY) begin
            r_state         <= (r_state == ST_PLAY) ? ST_PLAY_PAUSE : ST_PLAY;
            r_cmd.dsp_pause <= (r_state == ST_PLAY);
            r_cmd.dsp_start <= (r_state == ST_PLAY_PAUSE);
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  aud_sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC), .TIME_W(TIME_W)) u_rec_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state == ST_RECORD),
    .i_clr   (w_clr_rec),
    .o_time  (bus.o_record_time)
  );

  aud_sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC), .TIME_W(TIME_W)) u_play_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state == ST_PLAY),
    .i_clr   (w_clr_play),
    .o_time  (bus.o_play_time)
  );

  assign bus.o_i2c_start = r_i2c_start;
  assign bus.o_rec_start = r_cmd.rec_start;
  assign bus.o_rec_pause = r_cmd.rec_pause;
  assign bus.o_rec_stop  = r_cmd.rec_stop;
  assign bus.o_dsp_start = r_cmd.dsp_start;
  assign bus.o_dsp_pause = r_cmd.dsp_pause;
  assign bus.o_dsp_stop  = r_cmd.dsp_stop;
  assign bus.o_end_addr  = r_end_addr;
  assign bus.o_sram_rec  = r_sram_rec;
  assign bus.o_state     = r_state;
endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed + randomized bench for aud_mode_ctrl with a cycle-level reference
// model that tracks mode, active-cycle totals and the latched end address.
module tb_aud_mode_ctrl;
  localparam int TPS    = 10;
  localparam int ADDR_W = 20;
  localparam int TIME_W = 6;
  localparam int TMAX   = (1 << TIME_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aud_mode_ctrl_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) bus ();

  aud_mode_ctrl #(.TICKS_PER_SEC(TPS), .ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode uses the documented o_state numbering.
  int              m_mode;
  int              m_rec_cyc, m_play_cyc;
  logic [ADDR_W-1:0] m_end;
  bit              m_first;
  bit              e_i2c, e_rs, e_rp, e_rt, e_ds, e_dp, e_dt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rec_cyc = 0; m_play_cyc = 0; m_end = '0; m_first = 1'b1;
    {e_i2c, e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = '0;
  endtask

  task automatic model_step();
    bit st, rc, pl;
    st = bus.i_key_stop; rc = bus.i_key_record; pl = bus.i_key_play;
    {e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = '0;
    e_i2c = m_first; m_first = 1'b0;
    if (m_mode == 2) m_rec_cyc++;
    if (m_mode == 4) m_play_cyc++;
    case (m_mode)
      0: if (bus.i_init_done) m_mode = 1;
      1: if (st) ;
         else if (rc) begin m_mode = 2; e_rs = 1; m_rec_cyc = 0; end
         else if (pl && m_end != 0) begin m_mode = 4; e_ds = 1; m_play_cyc = 0; end
      2: if (st || bus.i_rec_full) begin m_mode = 1; e_rt = 1; m_end = bus.i_rec_addr; end
         else if (rc) begin m_mode = 3; e_rp = 1; end
      3: if (st) begin m_mode = 1; e_rt = 1; m_end = bus.i_rec_addr; end
         else if (rc) begin m_mode = 2; e_rs = 1; end
      4: if (st || bus.i_play_end) begin m_mode = 1; e_dt = 1; m_play_cyc = 0; end
         else if (pl) begin m_mode = 5; e_dp = 1; end
      5: if (st) begin m_mode = 1; e_dt = 1; m_play_cyc = 0; end
         else if (pl) begin m_mode = 4; e_ds = 1; end
      default: ;
    endcase
  endtask

  task automatic check_all(string ph);
    int rt, pt;
    rt = (m_rec_cyc / TPS > TMAX) ? TMAX : m_rec_cyc / TPS;
    pt = (m_play_cyc / TPS > TMAX) ? TMAX : m_play_cyc / TPS;
    check({ph, ".state"},     32'(bus.o_state),       32'(m_mode));
    check({ph, ".i2c"},       32'(bus.o_i2c_start),   32'(e_i2c));
    check({ph, ".rec_start"}, 32'(bus.o_rec_start),   32'(e_rs));
    check({ph, ".rec_pause"}, 32'(bus.o_rec_pause),   32'(e_rp));
    check({ph, ".rec_stop"},  32'(bus.o_rec_stop),    32'(e_rt));
    check({ph, ".dsp_start"}, 32'(bus.o_dsp_start),   32'(e_ds));
    check({ph, ".dsp_pause"}, 32'(bus.o_dsp_pause),   32'(e_dp));
    check({ph, ".dsp_stop"},  32'(bus.o_dsp_stop),    32'(e_dt));
    check({ph, ".end_addr"},  32'(bus.o_end_addr),    32'(m_end));
    check({ph, ".sram_rec"},  32'(bus.o_sram_rec),    32'(m_mode == 2 || m_mode == 3));
    check({ph, ".rec_time"},  32'(bus.o_record_time), 32'(rt));
    check({ph, ".play_time"}, 32'(bus.o_play_time),   32'(pt));
  endtask

  task automatic clear_inputs();
    bus.i_key_stop = 0; bus.i_key_record = 0; bus.i_key_play = 0;
    bus.i_init_done = 0; bus.i_rec_full = 0; bus.i_play_end = 0;
  endtask

  task automatic cycle(string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
    clear_inputs();
  endtask

  task automatic press(string ph, bit st, bit rc, bit pl);
    bus.i_key_stop = st; bus.i_key_record = rc; bus.i_key_play = pl;
    cycle(ph);
  endtask

  task automatic idle(string ph, int n);
    for (int i = 0; i < n; i++) cycle(ph);
  endtask

  initial begin
    clear_inputs();
    bus.i_rec_addr = 20'h0;
    model_reset();

    // Reset and codec-init kick-off
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    rst_n = 1'b1;
    cycle("i2c_pulse");
    check("i2c_first", 32'(bus.o_i2c_start), 32'd1);
    cycle("i2c_low");
    press("init_keys", 0, 1, 0);
    press("init_keys", 1, 0, 1);
    press("init_keys", 0, 0, 1);
    bus.i_init_done = 1;
    cycle("init_done");
    check("idle_state", 32'(bus.o_state), 32'd1);

    // Play with nothing recorded is ignored
    press("play_empty", 0, 0, 1);
    idle("play_empty", 3);

    // Record 35 cycles, stop at 0x01234
    press("rec_start", 0, 1, 0);
    idle("rec_run", 35);
    check("rec_time3", 32'(bus.o_record_time), 32'd3);
    bus.i_rec_addr = 20'h01234;
    press("rec_stop", 1, 0, 0);
    check("end_addr", 32'(bus.o_end_addr), 32'h01234);
    idle("rec_hold", 5);

    // Pause / resume without clearing
    press("rec2_start", 0, 1, 0);
    idle("rec2_run", 17);
    press("rec2_pause", 0, 1, 0);
    idle("rec2_frozen", 50);
    press("rec2_resume", 0, 1, 0);
    idle("rec2_run", 24);
    bus.i_rec_addr = 20'h00abc;
    press("rec2_stop", 1, 0, 0);

    // Playback, pause, resume, end-of-data
    press("play_start", 0, 0, 1);
    idle("play_run", 23);
    press("play_pause", 0, 0, 1);
    idle("play_frozen", 12);
    press("play_resume", 0, 0, 1);
    idle("play_run", 9);
    bus.i_play_end = 1;
    cycle("play_end");

    // rec_full beats simultaneous record key; all keys in IDLE is a no-op
    press("rec3_start", 0, 1, 0);
    idle("rec3_run", 6);
    bus.i_rec_addr = 20'h7ffff;
    bus.i_rec_full = 1;
    press("rec3_full", 0, 1, 0);
    press("idle_all", 1, 1, 1);
    idle("idle_all", 2);

    // Random key storm
    for (int i = 0; i < 2000; i++) begin
      bus.i_rec_addr  = ADDR_W'($urandom);
      bus.i_key_stop  = ($urandom_range(0, 24) == 0);
      bus.i_key_record = ($urandom_range(0, 14) == 0);
      bus.i_key_play  = ($urandom_range(0, 14) == 0);
      bus.i_rec_full  = ($urandom_range(0, 59) == 0);
      bus.i_play_end  = ($urandom_range(0, 49) == 0);
      bus.i_init_done = $urandom_range(0, 1);
      cycle("random");
    end

    // Saturation
    press("sat_stop", 1, 0, 0);
    press("sat_start", 0, 1, 0);
    idle("sat_run", 700);
    check("sat63", 32'(bus.o_record_time), 32'(TMAX));
    bus.i_rec_addr = 20'h00005;
    press("sat_stop", 1, 0, 0);

    // Reset in the middle of playback: no stop pulse, everything cleared
    press("rst_play", 0, 0, 1);
    idle("rst_play", 14);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold");
    check("rst_no_dsp_stop", 32'(bus.o_dsp_stop), 32'd0);
    rst_n = 1'b1;
    cycle("i2c_again");
    bus.i_init_done = 1;
    cycle("reinit");
    idle("reinit", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
